ps2_scancode_decoder: RTL and testbench



---
 rtl/ps2_scancode_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode parser: synchronises the receiver's byte flag, resolves
// E0/F0 prefixes into key events, tracks typematic repeats and a hex-key history.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scancode,
    input  logic        key_valid,
    output logic        event_valid,
    output logic [7:0]  event_code,
    output logic        event_break,
    output logic        event_ext,
    output logic        event_repeat,
    output logic        hex_valid,
    output logic [15:0] history,
    output logic        proto_err
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state, state_nx;
    logic            s1, s2, s3, strobe;
    logic [7:0]      byte_q;
    logic            byte_pend;
    logic [CW-1:0]   cnt;
    logic            timeout;
    logic            is_e0, is_f0, is_drop;
    logic            emit, emit_brk, emit_ext, stray_e0;
    logic            held_valid;
    logic [8:0]      held;
    logic            is_repeat;
    logic [3:0]      digit;
    logic            digit_hit;

    // Flops preset to 1 so a flag already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= key_valid;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign strobe = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q    <= '0;
            byte_pend <= 1'b0;
        end else begin
            byte_pend <= strobe;
            if (strobe)
                byte_q <= scancode;
        end
    end

    // A byte in flight (strobe or pending) always takes priority over expiry.
    assign timeout = (state != IDLE) && !strobe && !byte_pend &&
                     (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || strobe || byte_pend || timeout || state == IDLE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign is_e0   = (byte_q == 8'hE0);
    assign is_f0   = (byte_q == 8'hF0);
    assign is_drop = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hFE) ||
                     (byte_q == 8'hEE) || (byte_q == 8'h00) || (byte_q == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (byte_pend) begin
            unique case (state)
                IDLE: begin
                    if (is_e0)
                        state_nx = EXT;
                    else if (is_f0)
                        state_nx = BRK;
                end
                EXT: begin
                    if (is_f0)
                        state_nx = EXT_BRK;
                    else if (!is_e0)
                        state_nx = IDLE;
                end
                BRK, EXT_BRK: begin
                    if (is_e0)
                        state_nx = EXT;
                    else if (!is_f0)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        stray_e0 = 1'b0;
        if (byte_pend) begin
            unique case (state)
                IDLE: emit = !is_e0 && !is_f0 && !is_drop;
                EXT: begin
                    stray_e0 = is_e0;
                    emit     = !is_e0 && !is_f0;
                    emit_ext = 1'b1;
                end
                BRK, EXT_BRK: begin
                    stray_e0 = is_e0;
                    emit     = !is_e0 && !is_f0;
                    emit_brk = 1'b1;
                    emit_ext = (state == EXT_BRK);
                end
                default: ;
            endcase
        end
    end

    assign is_repeat = held_valid && (held == {emit_ext, byte_q});

    always_comb begin
        digit_hit = 1'b1;
        digit     = 4'h0;
        unique case (byte_q)
            8'h45: digit = 4'h0;
            8'h16: digit = 4'h1;
            8'h1E: digit = 4'h2;
            8'h26: digit = 4'h3;
            8'h25: digit = 4'h4;
            8'h2E: digit = 4'h5;
            8'h36: digit = 4'h6;
            8'h3D: digit = 4'h7;
            8'h3E: digit = 4'h8;
            8'h46: digit = 4'h9;
            8'h1C: digit = 4'hA;
            8'h32: digit = 4'hB;
            8'h21: digit = 4'hC;
            8'h23: digit = 4'hD;
            8'h24: digit = 4'hE;
            8'h2B: digit = 4'hF;
            default: digit_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_valid  <= 1'b0;
            event_code   <= '0;
            event_break  <= 1'b0;
            event_ext    <= 1'b0;
            event_repeat <= 1'b0;
            hex_valid    <= 1'b0;
            history      <= '0;
            proto_err    <= 1'b0;
            held_valid   <= 1'b0;
            held         <= '0;
        end else begin
            event_valid <= emit;
            hex_valid   <= 1'b0;
            proto_err   <= timeout | stray_e0;
            if (emit) begin
                event_code   <= byte_q;
                event_break  <= emit_brk;
                event_ext    <= emit_ext;
                event_repeat <= !emit_brk && is_repeat;
                if (emit_brk) begin
                    if (is_repeat)
                        held_valid <= 1'b0;
                end else if (!is_repeat) begin
                    held_valid <= 1'b1;
                    held       <= {emit_ext, byte_q};
                    if (!emit_ext && digit_hit) begin
                        hex_valid <= 1'b1;
                        history   <= {history[11:0], digit};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: expected key events are queued as bytes are sent and checked
// against the DUT's event pulses by a monitor; protocol errors are counted.
module tb_ps2_scancode_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  scancode;
    logic        key_valid;
    logic        event_valid;
    logic [7:0]  event_code;
    logic        event_break;
    logic        event_ext;
    logic        event_repeat;
    logic        hex_valid;
    logic [15:0] history;
    logic        proto_err;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .scancode(scancode), .key_valid(key_valid),
        .event_valid(event_valid), .event_code(event_code), .event_break(event_break),
        .event_ext(event_ext), .event_repeat(event_repeat), .hex_valid(hex_valid),
        .history(history), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  code;
        logic        brk;
        logic        ext;
        logic        rep;
        logic        hexv;
        logic [15:0] hist;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    int  perr_seen = 0;
    int  perr_exp = 0;
    int  ev_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] code, input logic brk, input logic ext,
                        input logic rep, input logic hexv, input logic [15:0] hist);
        ev_t e;
        e.code = code; e.brk = brk; e.ext = ext; e.rep = rep; e.hexv = hexv; e.hist = hist;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (proto_err)
                perr_seen++;
            if (event_valid) begin
                ev_seen++;
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'(q.size()), 32'd1);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_code",   32'(event_code),   32'(e.code));
                    chk("event_break",  32'(event_break),  32'(e.brk));
                    chk("event_ext",    32'(event_ext),    32'(e.ext));
                    chk("event_repeat", 32'(event_repeat), 32'(e.rep));
                    chk("hex_valid",    32'(hex_valid),    32'(e.hexv));
                    chk("history",      32'(history),      32'(e.hist));
                end
            end else if (hex_valid) begin
                chk("stray_hex_valid", 32'(hex_valid), 32'(event_valid));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scancode  = b;
        key_valid = 1'b1;
        repeat (6) @(negedge clk);
        key_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        reset     = 1'b1;
        key_valid = 1'b0;
        scancode  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({event_valid, event_code, event_break, event_ext, event_repeat, hex_valid, proto_err}),
            32'd0);
        chk("reset_history", 32'(history), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First press, with latency measured from the sampling edge
        push(8'h16, 0, 0, 0, 1, 16'h0001);
        @(negedge clk);
        scancode  = 8'h16;
        key_valid = 1'b1;
        n = 0;
        while (n < 20 && !event_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("event_latency", 32'(n), 32'd4);
        repeat (6) @(negedge clk);
        key_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Typematic repeat, release, fresh press
        do_reset();
        push(8'h1C, 0, 0, 0, 1, 16'h000A);
        send(8'h1C);
        push(8'h1C, 0, 0, 1, 0, 16'h000A);
        send(8'h1C);
        push(8'h1C, 0, 0, 1, 0, 16'h000A);
        send(8'h1C);
        send(8'hF0);
        push(8'h1C, 1, 0, 0, 0, 16'h000A);
        send(8'h1C);
        push(8'h1C, 0, 0, 0, 1, 16'h00AA);
        send(8'h1C);

        // Extended press and release
        push(8'h75, 0, 1, 0, 0, 16'h00AA);
        send(8'hE0);
        send(8'h75);
        push(8'h75, 1, 1, 0, 0, 16'h00AA);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("ext_no_perr", 32'(perr_seen), 32'(perr_exp));

        // Prefix timeout: F0 then silence
        @(negedge clk);
        scancode  = 8'hF0;
        key_valid = 1'b1;
        n = 0;
        while (n < 300 && !proto_err) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_cycle", 32'(n), 32'd104);
        perr_exp++;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("timeout_perr", 32'(perr_seen), 32'(perr_exp));
        push(8'h45, 0, 0, 0, 1, 16'h0AA0);
        send(8'h45);

        // Stray E0 inside a prefix
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        perr_exp++;
        chk("stray_e0_perr", 32'(perr_seen), 32'(perr_exp));
        push(8'h74, 0, 1, 0, 0, 16'h0AA0);
        send(8'h74);

        // AA after reset is dropped silently
        do_reset();
        base = ev_seen;
        send(8'hAA);
        chk("aa_dropped", 32'(ev_seen), 32'(base));
        chk("aa_history", 32'(history), 32'd0);

        // key_valid already high at reset release
        @(negedge clk);
        scancode  = 8'h16;
        key_valid = 1'b1;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("kv_high_at_reset", 32'(ev_seen), 32'(base));
        key_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Reset between F0 and the code discards the break prefix
        send(8'hF0);
        do_reset();
        push(8'h16, 0, 0, 0, 1, 16'h0001);
        send(8'h16);
        chk("reset_mid_prefix_perr", 32'(perr_seen), 32'(perr_exp));

        n = 0;
        while (n < 50 && q.size() != 0) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
